// File: rtl/bmem_line_arbiter_if.sv
// Signal bundle for bmem_line_arbiter: I/D cache line ports, bmem burst pins, error flag.
// master is the arbiter's view; slave is the caches-plus-memory environment.
interface bmem_line_arbiter_if #(
  parameter int BEAT_W = 64,
  parameter int BEATS  = 4
);
  localparam int LINE_W = BEAT_W * BEATS;

  logic [31:0]       i_addr;
  logic              i_read;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic [31:0]       d_addr;
  logic              d_read;
  logic              d_write;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic [31:0]       bmem_addr;
  logic              bmem_read;
  logic              bmem_write;
  logic [BEAT_W-1:0] bmem_wdata;
  logic              bmem_ready;
  logic [31:0]       bmem_raddr;
  logic [BEAT_W-1:0] bmem_rdata;
  logic              bmem_rvalid;

  logic              err;

  modport master (
    input  i_addr, i_read, d_addr, d_read, d_write, d_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
    output i_rdata, i_resp, d_rdata, d_resp,
    output bmem_addr, bmem_read, bmem_write, bmem_wdata, err
  );

  modport slave (
    output i_addr, i_read, d_addr, d_read, d_write, d_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
    input  i_rdata, i_resp, d_rdata, d_resp,
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata, err
  );
endinterface

// File: rtl/bmem_line_arbiter.sv
// Cacheline arbiter between the I/D caches and the banked burst DRAM.
// Issues one read or write burst at a time; returned beats are reassembled per port by address.
//
// state    | meaning
// IDLE     | pick the next eligible port (round-robin when both want service)
// RD_ISSUE | bmem_read held until the memory accepts the line request
// WR_BURST | D line streamed out beat by beat, advancing only on bmem_ready
module bmem_line_arbiter #(
  parameter int BEAT_W = 64,
  parameter int BEATS  = 4
) (
  input logic clk,
  input logic rst,
  bmem_line_arbiter_if.master bus
);
  localparam int LINE_W = BEAT_W * BEATS;
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

  typedef enum logic [1:0] {IDLE, RD_ISSUE, WR_BURST} state_t;

  state_t                   state;
  logic                     last_d;
  logic                     sel_d;
  logic [CW-1:0]            wcnt;
  logic [CW-1:0]            rcnt_i;
  logic [CW-1:0]            rcnt_d;
  logic                     pend_i;
  logic                     pend_d;
  logic [31:0]              paddr_i;
  logic [31:0]              paddr_d;
  logic [LINE_W-BEAT_W-1:0] rbuf_i;
  logic [LINE_W-BEAT_W-1:0] rbuf_d;

  logic i_elig;
  logic d_elig;
  logic pick_d;
  logic hit_d;
  logic hit_i;

  // A port whose resp is showing this cycle may still hold its request; it is not eligible yet.
  always_comb begin
    i_elig = bus.i_read && !pend_i && !bus.i_resp;
    d_elig = (bus.d_read || bus.d_write) && !pend_d && !bus.d_resp;
    pick_d = d_elig && (!i_elig || !last_d);
    hit_d  = bus.bmem_rvalid && pend_d && (bus.bmem_raddr == paddr_d);
    hit_i  = bus.bmem_rvalid && !hit_d && pend_i && (bus.bmem_raddr == paddr_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      last_d          <= 1'b0;
      sel_d           <= 1'b0;
      wcnt            <= '0;
      rcnt_i          <= '0;
      rcnt_d          <= '0;
      pend_i          <= 1'b0;
      pend_d          <= 1'b0;
      paddr_i         <= '0;
      paddr_d         <= '0;
      rbuf_i          <= '0;
      rbuf_d          <= '0;
      bus.bmem_addr   <= '0;
      bus.bmem_read   <= 1'b0;
      bus.bmem_write  <= 1'b0;
      bus.bmem_wdata  <= '0;
      bus.i_rdata     <= '0;
      bus.i_resp      <= 1'b0;
      bus.d_rdata     <= '0;
      bus.d_resp      <= 1'b0;
      bus.err         <= 1'b0;
    end else begin
      bus.i_resp <= 1'b0;
      bus.d_resp <= 1'b0;

      case (state)
        IDLE: begin
          if (pick_d) begin
            last_d        <= 1'b1;
            sel_d         <= 1'b1;
            bus.bmem_addr <= bus.d_addr & LINE_MASK;
            if (bus.d_write) begin
              wcnt           <= '0;
              bus.bmem_write <= 1'b1;
              bus.bmem_wdata <= bus.d_wdata[BEAT_W-1:0];
              state          <= WR_BURST;
            end else begin
              bus.bmem_read <= 1'b1;
              state         <= RD_ISSUE;
            end
          end else if (i_elig) begin
            last_d        <= 1'b0;
            sel_d         <= 1'b0;
            bus.bmem_addr <= bus.i_addr & LINE_MASK;
            bus.bmem_read <= 1'b1;
            state         <= RD_ISSUE;
          end
        end

        RD_ISSUE: begin
          if (bus.bmem_ready) begin
            bus.bmem_read <= 1'b0;
            state         <= IDLE;
            if (sel_d) begin
              pend_d  <= 1'b1;
              paddr_d <= bus.bmem_addr;
            end else begin
              pend_i  <= 1'b1;
              paddr_i <= bus.bmem_addr;
            end
          end
        end

        WR_BURST: begin
          if (bus.bmem_ready) begin
            if (wcnt == LAST) begin
              wcnt           <= '0;
              bus.bmem_write <= 1'b0;
              bus.d_resp     <= 1'b1;
              state          <= IDLE;
            end else begin
              wcnt           <= wcnt + CW'(1);
              bus.bmem_wdata <= bus.d_wdata[(wcnt + CW'(1)) * BEAT_W +: BEAT_W];
            end
          end
        end

        default: state <= IDLE;
      endcase

      // Beats arrive in order, so a shift register leaves beat 0 in the low slot.
      if (hit_d) begin
        if (rcnt_d == LAST) begin
          bus.d_rdata <= {bus.bmem_rdata, rbuf_d};
          bus.d_resp  <= 1'b1;
          pend_d      <= 1'b0;
          rcnt_d      <= '0;
        end else begin
          rbuf_d <= {bus.bmem_rdata, rbuf_d[LINE_W-BEAT_W-1:BEAT_W]};
          rcnt_d <= rcnt_d + CW'(1);
        end
      end

      if (hit_i) begin
        if (rcnt_i == LAST) begin
          bus.i_rdata <= {bus.bmem_rdata, rbuf_i};
          bus.i_resp  <= 1'b1;
          pend_i      <= 1'b0;
          rcnt_i      <= '0;
        end else begin
          rbuf_i <= {bus.bmem_rdata, rbuf_i[LINE_W-BEAT_W-1:BEAT_W]};
          rcnt_i <= rcnt_i + CW'(1);
        end
      end

      if (bus.bmem_rvalid && !hit_d && !hit_i) bus.err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_bmem_line_arbiter.sv
// Bench for bmem_line_arbiter: directed scenarios, then random cache/memory traffic
// checked against a line-level memory model.
module tb_bmem_line_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  bmem_line_arbiter_if #(.BEAT_W(64), .BEATS(4)) bus ();
  bmem_line_arbiter #(.BEAT_W(64), .BEATS(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0]  a;
    logic [255:0] line;
  } burst_t;

  logic [255:0] mem [logic [31:0]];
  burst_t       bq [$];
  burst_t       cur;
  bit           pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_rd(input string tag);
    for (int k = 0; k < 20 && !bus.bmem_read; k++) step();
    chk(tag, bus.bmem_read, 1);
  endtask

  task automatic wait_wr(input string tag);
    for (int k = 0; k < 20 && !bus.bmem_write; k++) step();
    chk(tag, bus.bmem_write, 1);
  endtask

  task automatic send_line(input logic [31:0] a, input logic [255:0] line);
    for (int k = 0; k < 4; k++) begin
      bus.bmem_rvalid = 1'b1;
      bus.bmem_raddr  = a;
      bus.bmem_rdata  = line[k*64 +: 64];
      step();
    end
    bus.bmem_rvalid = 1'b0;
  endtask

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & 32'hFFFF_FFE0;
  endfunction

  function automatic logic [255:0] get_line(input logic [31:0] a);
    logic [255:0] l;
    if (mem.exists(a)) return mem[a];
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = a ^ (k * 32'h9E37_79B9);
    return l;
  endfunction

  function automatic logic [255:0] rnd_line();
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [255:0] beat_line(input logic [63:0] base);
    logic [255:0] l;
    for (int k = 0; k < 4; k++) l[k*64 +: 64] = base | 64'(k);
    return l;
  endfunction

  // Random-phase model state: per-port request bookkeeping and the memory's return queue.
  bit           i_busy, i_iss, d_busy, d_wr, d_iss, cur_v;
  logic [31:0]  i_a, d_a;
  logic [255:0] d_w;
  int           i_exp, d_exp, d_k, cur_k;

  initial begin
    logic [255:0] l1, li, ld, w;
    int nacc;

    bus.i_addr = '0; bus.i_read = 1'b0;
    bus.d_addr = '0; bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_wdata = '0;
    bus.bmem_ready = 1'b0; bus.bmem_raddr = '0; bus.bmem_rdata = '0; bus.bmem_rvalid = 1'b0;

    do_reset();
    chk("rst_ctl", {bus.bmem_addr, bus.bmem_read, bus.bmem_write, bus.bmem_wdata,
                    bus.i_resp, bus.d_resp, bus.err}, 0);
    chk("rst_lines", bus.i_rdata | bus.d_rdata, 0);

    // I read, unaligned address
    bus.i_addr = 32'h1000_0024; bus.i_read = 1'b1;
    wait_rd("t1_rd_issue");
    chk("t1_addr", bus.bmem_addr, 32'h1000_0020);
    bus.bmem_ready = 1'b1;
    step();
    bus.bmem_ready = 1'b0;
    chk("t1_one_read", bus.bmem_read, 0);
    l1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    send_line(32'h1000_0020, l1);
    chk("t1_i_resp", bus.i_resp, 1);
    chk("t1_i_rdata", bus.i_rdata, l1);
    bus.i_read = 1'b0;
    step();
    chk("t1_resp_pulse", bus.i_resp, 0);

    // D write with stalling ready
    w = beat_line(64'hA5A5_0000_0000_0000);
    bus.d_addr = 32'h2000_0000; bus.d_wdata = w; bus.d_write = 1'b1;
    wait_wr("t2_wr_start");
    nacc = 0;
    for (int i = 0; i < 6; i++) begin
      chk("t2_wr_valid", bus.bmem_write, 1);
      chk("t2_wr_addr", bus.bmem_addr, 32'h2000_0000);
      chk("t2_wr_beat", bus.bmem_wdata, w[nacc*64 +: 64]);
      chk("t2_no_early_resp", bus.d_resp, 0);
      bus.bmem_ready = pat[i];
      if (pat[i]) nacc++;
      step();
    end
    chk("t2_d_resp", bus.d_resp, 1);
    chk("t2_wr_done", bus.bmem_write, 0);
    bus.d_write = 1'b0; bus.bmem_ready = 1'b0;
    step();
    chk("t2_resp_pulse", bus.d_resp, 0);

    // Simultaneous I and D reads: D favoured after reset; returns out of order
    do_reset();
    bus.bmem_ready = 1'b1;
    bus.i_addr = 32'h3000_0040; bus.i_read = 1'b1;
    bus.d_addr = 32'h4000_0080; bus.d_read = 1'b1;
    wait_rd("t3_first_rd");
    chk("t3_first_is_d", bus.bmem_addr, 32'h4000_0080);
    step();
    wait_rd("t3_second_rd");
    chk("t3_second_is_i", bus.bmem_addr, 32'h3000_0040);
    step();
    bus.bmem_ready = 1'b0;
    li = rnd_line();
    ld = rnd_line();
    send_line(32'h3000_0040, li);
    chk("t3_i_resp", bus.i_resp, 1);
    chk("t3_d_not_yet", bus.d_resp, 0);
    chk("t3_i_rdata", bus.i_rdata, li);
    bus.i_read = 1'b0;
    send_line(32'h4000_0080, ld);
    chk("t3_d_resp", bus.d_resp, 1);
    chk("t3_d_rdata", bus.d_rdata, ld);
    bus.d_read = 1'b0;
    step();

    // Write burst overlapping I's returning beats
    bus.bmem_ready = 1'b1;
    bus.i_addr = 32'h5000_0000; bus.i_read = 1'b1;
    wait_rd("t4_rd_issue");
    step();
    w = rnd_line();
    li = rnd_line();
    bus.d_addr = 32'h6000_0000; bus.d_wdata = w; bus.d_write = 1'b1;
    wait_wr("t4_wr_start");
    for (int k = 0; k < 4; k++) begin
      chk("t4_wr_beat", bus.bmem_wdata, w[k*64 +: 64]);
      bus.bmem_rvalid = 1'b1;
      bus.bmem_raddr  = 32'h5000_0000;
      bus.bmem_rdata  = li[k*64 +: 64];
      step();
    end
    bus.bmem_rvalid = 1'b0;
    chk("t4_i_resp", bus.i_resp, 1);
    chk("t4_d_resp", bus.d_resp, 1);
    chk("t4_i_rdata", bus.i_rdata, li);
    bus.i_read = 1'b0; bus.d_write = 1'b0; bus.bmem_ready = 1'b0;
    step();

    // Unmatched beat sets sticky err
    chk("t5_err_clear", bus.err, 0);
    bus.bmem_rvalid = 1'b1; bus.bmem_raddr = 32'hDEAD_0000; bus.bmem_rdata = 64'h1;
    step();
    bus.bmem_rvalid = 1'b0;
    chk("t5_err_set", bus.err, 1);
    step(); step(); step();
    chk("t5_err_sticky", bus.err, 1);
    chk("t5_no_resp", {bus.i_resp, bus.d_resp}, 0);
    do_reset();
    chk("t5_err_rst", bus.err, 0);

    // Reset in the middle of a write burst, then a clean write
    w = rnd_line();
    bus.d_addr = 32'h7000_0000; bus.d_wdata = w; bus.d_write = 1'b1; bus.bmem_ready = 1'b1;
    wait_wr("t6_wr_start");
    step(); step();
    rst = 1'b1; bus.bmem_ready = 1'b0;
    step();
    chk("t6_rst_ctl", {bus.bmem_addr, bus.bmem_read, bus.bmem_write, bus.bmem_wdata,
                       bus.i_resp, bus.d_resp, bus.err}, 0);
    rst = 1'b0;
    w = rnd_line();
    bus.d_wdata = w; bus.bmem_ready = 1'b1;
    wait_wr("t6_restart");
    for (int k = 0; k < 4; k++) begin
      chk("t6_wr_beat", bus.bmem_wdata, w[k*64 +: 64]);
      step();
    end
    chk("t6_d_resp", bus.d_resp, 1);
    bus.d_write = 1'b0; bus.bmem_ready = 1'b0;
    step();

    // Random traffic: I reads its own region, D reads/writes a separate region
    do_reset();
    i_busy = 0; i_iss = 0; d_busy = 0; d_wr = 0; d_iss = 0; cur_v = 0;
    i_exp = -1; d_exp = -1; d_k = 0; cur_k = 0;
    for (int t = 0; t < 3500; t++) begin
      bit issue_ok;
      issue_ok = (t < 3000);

      if (bus.i_resp) begin
        if (!i_busy || i_exp < 0) chk("rnd_i_resp_unexp", bus.i_resp, 0);
        else begin
          chk("rnd_i_resp_t", cyc, i_exp);
          chk("rnd_i_rdata", bus.i_rdata, get_line(align(i_a)));
        end
        i_busy = 0; i_exp = -1; bus.i_read = 1'b0;
      end
      if (bus.d_resp) begin
        if (!d_busy || d_exp < 0) chk("rnd_d_resp_unexp", bus.d_resp, 0);
        else if (d_wr) begin
          chk("rnd_wr_resp_t", cyc, d_exp);
          chk("rnd_wr_beats", d_k, 4);
        end else begin
          chk("rnd_d_resp_t", cyc, d_exp);
          chk("rnd_d_rdata", bus.d_rdata, get_line(align(d_a)));
        end
        d_busy = 0; d_exp = -1; bus.d_read = 1'b0; bus.d_write = 1'b0;
      end

      // Memory returns one queued burst at a time, chosen at random, with random gaps
      bus.bmem_rvalid = 1'b0;
      if (!cur_v && bq.size() > 0 && $urandom_range(0, 3) == 0) begin
        int idx;
        idx = $urandom_range(0, bq.size() - 1);
        cur = bq[idx];
        bq.delete(idx);
        cur_v = 1; cur_k = 0;
      end
      if (cur_v && $urandom_range(0, 9) < 7) begin
        bus.bmem_rvalid = 1'b1;
        bus.bmem_raddr  = cur.a;
        bus.bmem_rdata  = cur.line[cur_k*64 +: 64];
        cur_k++;
        if (cur_k == 4) begin
          cur_v = 0;
          if (d_busy && !d_wr && d_iss && cur.a == align(d_a)) d_exp = cyc + 1;
          else i_exp = cyc + 1;
        end
      end

      bus.bmem_ready = ($urandom_range(0, 9) < 7);
      if (bus.bmem_read && bus.bmem_ready) begin
        if (d_busy && !d_wr && !d_iss && bus.bmem_addr == align(d_a)) d_iss = 1;
        else if (i_busy && !i_iss && bus.bmem_addr == align(i_a)) i_iss = 1;
        else chk("rnd_rd_issue_addr", bus.bmem_addr, align(i_a));
        bq.push_back('{bus.bmem_addr, get_line(bus.bmem_addr)});
      end
      if (bus.bmem_write && bus.bmem_ready) begin
        if (d_busy && d_wr && d_k < 4) begin
          chk("rnd_wr_addr", bus.bmem_addr, align(d_a));
          chk("rnd_wr_beat", bus.bmem_wdata, d_w[d_k*64 +: 64]);
          d_k++;
          if (d_k == 4) begin
            mem[align(d_a)] = d_w;
            d_exp = cyc + 1;
          end
        end else chk("rnd_wr_unexp", bus.bmem_write, 0);
      end

      if (issue_ok && !i_busy && $urandom_range(0, 3) == 0) begin
        i_busy = 1; i_iss = 0; i_exp = -1;
        i_a = 32'h1000_0000 + {$urandom_range(0, 7), 5'h0} + 32'($urandom_range(0, 31));
        bus.i_addr = i_a; bus.i_read = 1'b1;
      end
      if (issue_ok && !d_busy && $urandom_range(0, 3) == 0) begin
        d_busy = 1; d_iss = 0; d_exp = -1; d_k = 0;
        d_wr = $urandom_range(0, 1) == 1;
        d_a = 32'h8000_0000 + {$urandom_range(0, 3), 5'h0} + 32'($urandom_range(0, 31));
        d_w = rnd_line();
        bus.d_addr = d_a; bus.d_wdata = d_w;
        bus.d_write = d_wr; bus.d_read = !d_wr;
      end
      step();
    end
    chk("rnd_drained", {i_busy, d_busy}, 0);
    chk("rnd_err_final", bus.err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
